// File: rtl/tile_fetch_scheduler.sv
// Single-port tile VRAM sequencer: prefetches name/pattern/colour one tile ahead of the beam
// and hands every slot the fetch does not need to the host write port.
module tile_fetch_scheduler #(
  parameter logic [13:0] NAME_BASE = 14'h0000,
  parameter logic [13:0] PAT_BASE  = 14'h0800,
  parameter logic [13:0] COL_BASE  = 14'h1000,
  parameter int          TILE_COLS = 32,
  parameter int          TILE_ROWS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [13:0] vram_addr,
  output logic        vram_rd,
  output logic        vram_wr,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  input  logic        host_req,
  input  logic [13:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  tile_pattern,
  output logic [7:0]  tile_color,
  output logic        tile_valid
);

  localparam logic [6:0] LAST_FETCH_WIN = 7'(TILE_COLS - 2);
  localparam logic [6:0] WRAP_WIN       = 7'd99;   // hcount 1584..1599
  localparam logic [9:0] LAST_LINE      = 10'd524;
  localparam logic [9:0] ACTIVE_LINES   = 10'(TILE_ROWS * 8);

  typedef enum logic [2:0] {
    SLOT_HOST,
    SLOT_NAME,
    SLOT_PAT,
    SLOT_COL,
    SLOT_BLOCKED
  } slot_e;

  logic [3:0] w_phase;
  logic [6:0] w_win;
  logic       w_has_target;
  logic [9:0] w_target_line;
  logic [4:0] w_target_col;
  logic       w_fetch_win;
  slot_e      w_slot;

  logic       r_fetch_live;
  logic [7:0] r_name;
  logic [7:0] r_pat_sh;
  logic [7:0] r_col_sh;
  logic [7:0] r_tile_pattern;
  logic [7:0] r_tile_color;
  logic       r_tile_valid;

  assign w_phase = hcount[3:0];
  assign w_win   = hcount[10:4];

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_has_target  = 1'b0;
    w_target_line = vcount;
    w_target_col  = 5'd0;
    if (w_win <= LAST_FETCH_WIN) begin
      w_has_target = 1'b1;
      w_target_col = w_win[4:0] + 5'd1;
    end else if (w_win == WRAP_WIN) begin
      w_has_target  = 1'b1;
      w_target_line = (vcount == LAST_LINE) ? 10'd0 : vcount + 10'd1;
    end
  end

  assign w_fetch_win = w_has_target && (w_target_line < ACTIVE_LINES);

  // Pattern/colour reads need a name latched in this window; an abandoned window skips them.
  always_comb begin
    w_slot = SLOT_HOST;
    if (w_fetch_win) begin
      unique case (w_phase)
        4'd0:                 w_slot = SLOT_NAME;
        4'd2:                 w_slot = r_fetch_live ? SLOT_PAT : SLOT_BLOCKED;
        4'd3:                 w_slot = r_fetch_live ? SLOT_COL : SLOT_BLOCKED;
        4'd1, 4'd4, 4'd15:    w_slot = SLOT_BLOCKED;
        default:              w_slot = SLOT_HOST;
      endcase
    end
  end

  always_comb begin
    vram_rd    = 1'b0;
    vram_wr    = 1'b0;
    vram_addr  = 14'd0;
    vram_wdata = 8'd0;
    host_ack   = 1'b0;
    if (!reset) begin
      unique case (w_slot)
        SLOT_NAME: begin
          vram_rd   = 1'b1;
          vram_addr = NAME_BASE + 14'({w_target_line[7:3], w_target_col});
        end
        SLOT_PAT: begin
          vram_rd   = 1'b1;
          vram_addr = PAT_BASE + 14'({r_name, w_target_line[2:0]});
        end
        SLOT_COL: begin
          vram_rd   = 1'b1;
          vram_addr = COL_BASE + 14'(r_name[7:3]);
        end
        SLOT_HOST: begin
          if (host_req) begin
            vram_wr    = 1'b1;
            vram_addr  = host_addr;
            vram_wdata = host_wdata;
            host_ack   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_live   <= 1'b0;
      r_name         <= 8'd0;
      r_pat_sh       <= 8'd0;
      r_col_sh       <= 8'd0;
      r_tile_pattern <= 8'd0;
      r_tile_color   <= 8'd0;
      r_tile_valid   <= 1'b0;
    end else begin
      if (w_phase == 4'd0)
        r_fetch_live <= w_fetch_win;
      if (r_fetch_live) begin
        unique case (w_phase)
          4'd1:    r_name   <= vram_rdata;
          4'd3:    r_pat_sh <= vram_rdata;
          4'd4:    r_col_sh <= vram_rdata;
          default: ;
        endcase
      end
      if (w_phase == 4'd15) begin
        r_tile_valid   <= r_fetch_live;
        r_tile_pattern <= r_fetch_live ? r_pat_sh : 8'd0;
        r_tile_color   <= r_fetch_live ? r_col_sh : 8'd0;
      end
    end
  end

  assign tile_pattern = r_tile_pattern;
  assign tile_color   = r_tile_color;
  assign tile_valid   = r_tile_valid;

endmodule

// File: tb/tb_tile_fetch_scheduler.sv
// Scoreboard bench for tile_fetch_scheduler: VRAM model, directed scenarios, then randomized
// windows with random host writes and reset pulses, checked against a phase-level reference.
module tb_tile_fetch_scheduler;

  localparam logic [13:0] NAME_BASE = 14'h0000;
  localparam logic [13:0] PAT_BASE  = 14'h0800;
  localparam logic [13:0] COL_BASE  = 14'h1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [13:0] vram_addr;
  logic        vram_rd, vram_wr;
  logic [7:0]  vram_wdata, vram_rdata;
  logic        host_req;
  logic [13:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  tile_pattern, tile_color;
  logic        tile_valid;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:16383];
  logic [21:0] host_q[$];
  logic [16:0] tile_q[$];

  always #5 clk = ~clk;

  tile_fetch_scheduler dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_wr(vram_wr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .tile_pattern(tile_pattern), .tile_color(tile_color),
    .tile_valid(tile_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // VRAM: 1-cycle read latency; garbage on rdata whenever no read was issued.
  initial begin : vram
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem[14'h0000] = 8'h04;
    mem[14'h0820] = 8'hAA;
    mem[14'h1000] = 8'h4F;
    vram_rdata = 8'h00;
    forever begin
      @(posedge clk);
      vram_rdata <= vram_rd ? mem[vram_addr] : 8'($urandom);
      if (vram_wr) mem[vram_addr] <= vram_wdata;
    end
  end

  // Which tile (line, col) a window prefetches; returns 1 only if it lies in the display area.
  function automatic bit target(input logic [10:0] h, input logic [9:0] v,
                                output int line, output int col);
    int w;
    w = int'(h[10:4]);
    line = 0;
    col = 0;
    if (w <= 30) begin
      line = int'(v);
      col = w + 1;
    end else if (w == 99) begin
      line = (v == 10'd524) ? 0 : int'(v) + 1;
      col = 0;
    end else begin
      return 1'b0;
    end
    return line < 192;
  endfunction

  int          prev_p = 0;
  bit          prev_reset = 1'b1;
  bit          started = 1'b0;
  logic [16:0] exp_cur = 17'd0;
  logic [7:0]  snap_name, snap_pat, snap_col;

  always @(negedge clk) begin : monitor
    int          p, line, col;
    bit          fw;
    logic        e_rd, e_wr, e_ack;
    logic [13:0] e_addr;
    logic [7:0]  e_wd;
    logic [21:0] hw;
    p = int'(hcount[3:0]);
    fw = target(hcount, vcount, line, col);

    if (prev_p == 15) exp_cur = (tile_q.size() > 0) ? tile_q.pop_front() : 17'd0;
    if (prev_reset) exp_cur = 17'd0;
    check("tile_out", 32'({tile_valid, tile_pattern, tile_color}), 32'(exp_cur));

    if (p == 0) begin
      started = fw && !reset;
      if (fw) begin
        snap_name = mem[14'(int'(NAME_BASE) + (line / 8) * 32 + col)];
        snap_pat  = mem[14'(int'(PAT_BASE) + int'(snap_name) * 8 + line % 8)];
        snap_col  = mem[14'(int'(COL_BASE) + int'(snap_name) / 8)];
      end
    end

    e_rd = 1'b0; e_wr = 1'b0; e_ack = 1'b0; e_addr = 14'd0; e_wd = 8'd0;
    if (!reset) begin
      if (fw && p == 0) begin
        e_rd = 1'b1;
        e_addr = 14'(int'(NAME_BASE) + (line / 8) * 32 + col);
      end else if (fw && started && p == 2) begin
        e_rd = 1'b1;
        e_addr = 14'(int'(PAT_BASE) + int'(snap_name) * 8 + line % 8);
      end else if (fw && started && p == 3) begin
        e_rd = 1'b1;
        e_addr = 14'(int'(COL_BASE) + int'(snap_name) / 8);
      end else if (host_req && (!fw || (p >= 5 && p <= 14))) begin
        e_wr = 1'b1; e_ack = 1'b1; e_addr = host_addr; e_wd = host_wdata;
      end
    end
    check("vram_bus", 32'({vram_rd, vram_wr, host_ack, vram_addr, vram_wdata}),
          32'({e_rd, e_wr, e_ack, e_addr, e_wd}));

    if (host_ack) begin
      if (host_q.size() > 0) begin
        hw = host_q.pop_front();
        check("host_write", 32'({vram_addr, vram_wdata}), 32'(hw));
      end else begin
        checks++;
        failures++;
        $display("FAIL host_spurious: ack with empty queue, addr %h data %h", vram_addr, vram_wdata);
      end
    end

    if (p == 15) tile_q.push_back((started && fw && !reset) ? {1'b1, snap_pat, snap_col} : 17'd0);
    if (reset) started = 1'b0;
    prev_p = p;
    prev_reset = reset;
  end

  task automatic run_window(input int c, input int line,
                            output logic [7:0] pat, output logic [7:0] col, output logic v);
    for (int p = 0; p < 16; p++) begin
      hcount = 11'(c * 16 + p);
      vcount = 10'(line);
      if (p == 0) begin
        @(negedge clk);
        pat = tile_pattern;
        col = tile_color;
        v = tile_valid;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic host_write(input logic [13:0] a, input logic [7:0] d, input int delay,
                            output int waited, output bit ok);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk);
      #1;
    end
    host_q.push_back({a, d});
    host_req = 1'b1;
    host_addr = a;
    host_wdata = d;
    waited = 0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (host_ack) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    @(posedge clk);
    #1;
    host_req = 1'b0;
    check("host_timeout", 32'(ok), 32'(1));
    if (!ok) void'(host_q.pop_back());
  endtask

  initial begin : main
    logic [7:0] tp, tc;
    logic       tv;
    int         w;
    bit         ok, hdone;

    reset = 1'b1; hcount = 11'd600; vcount = 10'd0;
    host_req = 1'b0; host_addr = 14'd0; host_wdata = 8'd0;

    // Request pending through reset is granted on the first cycle after release.
    fork
      begin
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;
      end
      host_write(14'h2345, 8'hC3, 0, w, ok);
    join
    check("host_after_reset_wait", 32'(w), 32'(2));

    // Wrap window at line 524 fetches column 0 of line 0.
    run_window(99, 524, tp, tc, tv);
    run_window(0, 0, tp, tc, tv);
    check("wrap_tile_pattern", 32'(tp), 32'(8'hAA));
    check("wrap_tile_color", 32'(tc), 32'(8'h4F));
    check("wrap_tile_valid", 32'(tv), 32'(1));

    // Last visible tile of line 191, then nothing for line 192.
    run_window(30, 191, tp, tc, tv);
    run_window(99, 191, tp, tc, tv);
    check("line191_col31_valid", 32'(tv), 32'(1));
    run_window(0, 192, tp, tc, tv);
    check("line192_invalid_a", 32'(tv), 32'(0));
    run_window(15, 192, tp, tc, tv);
    check("line192_invalid_b", 32'(tv), 32'(0));

    // Request at p0 of a fetch window waits for p5.
    fork
      run_window(5, 10, tp, tc, tv);
      host_write(14'h0123, 8'h5A, 0, w, ok);
    join
    check("host_p0_wait", 32'(w), 32'(5));

    // Back-to-back writes through a host-only window: one ack per cycle.
    fork
      run_window(37, 50, tp, tc, tv);
      begin
        for (int i = 0; i < 16; i++) begin
          host_write(14'($urandom), 8'($urandom), 0, w, ok);
          check("b2b_wait", 32'(w), 32'(0));
        end
      end
    join

    // Reset during p2 of column 5 abandons that window's fetch.
    run_window(4, 30, tp, tc, tv);
    fork
      run_window(5, 30, tp, tc, tv);
      begin
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_clear", 32'({tile_valid, tile_pattern, tile_color}), 32'(0));
      end
    join
    check("rst_prev_valid", 32'(tv), 32'(1));
    run_window(6, 30, tp, tc, tv);
    check("rst_abandoned", 32'(tv), 32'(0));
    run_window(7, 30, tp, tc, tv);
    check("rst_recovered", 32'(tv), 32'(1));

    // Request arriving at p15 is the worst case: granted at p5 of the next window.
    fork
      begin
        run_window(3, 20, tp, tc, tv);
        run_window(4, 20, tp, tc, tv);
      end
      host_write(14'h0456, 8'h3C, 15, w, ok);
    join
    check("host_p15_wait", 32'(w), 32'(6));

    // Randomized windows, host traffic and occasional reset pulses.
    hdone = 1'b0;
    fork
      begin
        int w2;
        bit ok2;
        for (int k = 0; k < 150; k++)
          host_write(14'($urandom), 8'($urandom), int'($urandom_range(0, 20)), w2, ok2);
        hdone = 1'b1;
      end
      begin
        logic [7:0] tp2, tc2;
        logic       tv2;
        int         c, l, pick, rp;
        while (!hdone) begin
          pick = int'($urandom_range(0, 9));
          c = (pick < 6) ? int'($urandom_range(0, 30)) :
              (pick < 8) ? 99 : int'($urandom_range(31, 98));
          l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(185, 524))
                                          : int'($urandom_range(0, 191));
          rp = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 14)) : -1;
          fork
            run_window(c, l, tp2, tc2, tv2);
            begin
              if (rp >= 0) begin
                for (int i = 0; i < rp; i++) begin @(posedge clk); #1; end
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
              end
            end
          join
        end
      end
    join

    run_window(0, 0, tp, tc, tv);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
